router_pkt_src: RTL and testbench

Store-and-forward packet source that sits directly upstream of the 1x3 router and drives its `pkt_valid`/`data_in` pins. It accepts a transmit request with destination and length, collects the payload from a host valid/ready stream into an internal 64x8 buffer, and computes parity while loading. It then emits header, payload and parity bytes back-to-back, obeying the router's `busy` back-pressure, so `pkt_valid` never drops mid-payload.

---
 rtl/router_pkt_src.sv | 216 +++++++++++++++++++++
 tb/tb_router_pkt_src.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/router_pkt_src.sv
// router_pkt_src: store-and-forward packet source feeding the 1x3 router.
// Loads a payload from the host, then emits header, payload and parity bytes.
module router_pkt_src #(
    parameter int GAP_CYCLES = 2,
    parameter int STALL_MAX  = 16
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest,
    input  logic [5:0] len,
    input  logic       pay_valid,
    input  logic [7:0] pay_data,
    input  logic       busy,
    output logic       pay_ready,
    output logic       pkt_valid,
    output logic [7:0] data_out,
    output logic       tx_active,
    output logic       done,
    output logic       req_err,
    output logic       stall_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_HDR,
        S_PAY,
        S_PAR,
        S_GAP
    } state_e;

    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);
    localparam logic [7:0] SMAX     = 8'(STALL_MAX);

    state_e     state_q, state_d;
    logic [1:0] dest_q, dest_d;
    logic [5:0] len_q, len_d;
    logic [5:0] cnt_q, cnt_d;
    logic [5:0] idx_q, idx_d;
    logic [7:0] par_q, par_d;
    logic [3:0] gap_q, gap_d;
    logic [7:0] stall_q, stall_d;
    logic [7:0] data_q, data_d;
    logic       pkt_valid_q, pkt_valid_d;
    logic       pay_ready_q, pay_ready_d;
    logic       tx_active_q, tx_active_d;
    logic       done_q, done_d;
    logic       req_err_q, req_err_d;
    logic       stall_err_q, stall_err_d;

    logic [7:0] mem_q [64];
    logic       wr_en;
    logic       tx_phase;

    // in LOAD pay_ready is high, so a valid byte is always accepted
    assign wr_en    = (state_q == S_LOAD) && pay_valid;
    assign tx_phase = (state_q == S_HDR) || (state_q == S_PAY) ||
                      (state_q == S_PAR);

    // payload buffer, contents are don't-care after reset
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem_q[cnt_q] <= pay_data;
        end
    end

    // next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        dest_d      = dest_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        par_d       = par_q;
        gap_d       = gap_q;
        stall_d     = stall_q;
        data_d      = data_q;
        pkt_valid_d = pkt_valid_q;
        pay_ready_d = pay_ready_q;
        tx_active_d = tx_active_q;
        stall_err_d = stall_err_q;
        done_d      = 1'b0;
        req_err_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (dest == 2'd3 || len == 6'd0) begin
                        req_err_d = 1'b1;
                    end else begin
                        dest_d      = dest;
                        len_d       = len;
                        par_d       = {len, dest};
                        cnt_d       = 6'd0;
                        stall_d     = 8'd0;
                        stall_err_d = 1'b0;
                        pay_ready_d = 1'b1;
                        tx_active_d = 1'b1;
                        state_d     = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (pay_valid) begin
                    par_d = par_q ^ pay_data;
                    cnt_d = cnt_q + 6'd1;
                    if (cnt_q == len_q - 6'd1) begin
                        pay_ready_d = 1'b0;
                        pkt_valid_d = 1'b1;
                        data_d      = {len_q, dest_q};
                        state_d     = S_HDR;
                    end
                end
            end
            S_HDR: begin
                if (!busy) begin
                    data_d  = mem_q[0];
                    idx_d   = 6'd0;
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                if (!busy) begin
                    if (idx_q < len_q - 6'd1) begin
                        idx_d  = idx_q + 6'd1;
                        data_d = mem_q[idx_q + 6'd1];
                    end else begin
                        data_d      = par_q;
                        pkt_valid_d = 1'b0;
                        state_d     = S_PAR;
                    end
                end
            end
            S_PAR: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    data_d  = 8'd0;
                    gap_d   = 4'd0;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    tx_active_d = 1'b0;
                    state_d     = S_IDLE;
                end else begin
                    gap_d = gap_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // back-pressure watchdog, saturates so it never wraps
        if (tx_phase) begin
            if (busy) begin
                if (stall_q < SMAX) begin
                    stall_d = stall_q + 8'd1;
                end
                if (stall_q >= SMAX - 8'd1) begin
                    stall_err_d = 1'b1;
                end
            end else begin
                stall_d = 8'd0;
            end
        end
    end

    // state and output registers, cleared asynchronously
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            dest_q      <= 2'd0;
            len_q       <= 6'd0;
            cnt_q       <= 6'd0;
            idx_q       <= 6'd0;
            par_q       <= 8'd0;
            gap_q       <= 4'd0;
            stall_q     <= 8'd0;
            data_q      <= 8'd0;
            pkt_valid_q <= 1'b0;
            pay_ready_q <= 1'b0;
            tx_active_q <= 1'b0;
            done_q      <= 1'b0;
            req_err_q   <= 1'b0;
            stall_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dest_q      <= dest_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            par_q       <= par_d;
            gap_q       <= gap_d;
            stall_q     <= stall_d;
            data_q      <= data_d;
            pkt_valid_q <= pkt_valid_d;
            pay_ready_q <= pay_ready_d;
            tx_active_q <= tx_active_d;
            done_q      <= done_d;
            req_err_q   <= req_err_d;
            stall_err_q <= stall_err_d;
        end
    end

    assign pay_ready = pay_ready_q;
    assign pkt_valid = pkt_valid_q;
    assign data_out  = data_q;
    assign tx_active = tx_active_q;
    assign done      = done_q;
    assign req_err   = req_err_q;
    assign stall_err = stall_err_q;

endmodule

// File: tb/tb_router_pkt_src.sv
// tb_router_pkt_src: directed and randomized packets checked against a
// byte-list model of header, payload, parity and busy-run stall tracking.
module tb_router_pkt_src;

    localparam int GAP   = 2;
    localparam int SMAX  = 16;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [1:0] dest;
    logic [5:0] len;
    logic       pay_valid;
    logic [7:0] pay_data;
    logic       busy;
    logic       pay_ready;
    logic       pkt_valid;
    logic [7:0] data_out;
    logic       tx_active;
    logic       done;
    logic       req_err;
    logic       stall_err;

    int checks;
    int errors;

    logic [7:0] pay_q[$];
    logic [7:0] obs_q[$];

    router_pkt_src #(
        .GAP_CYCLES(GAP),
        .STALL_MAX (SMAX)
    ) dut (
        .clock    (clock),
        .resetn   (resetn),
        .start    (start),
        .dest     (dest),
        .len      (len),
        .pay_valid(pay_valid),
        .pay_data (pay_data),
        .busy     (busy),
        .pay_ready(pay_ready),
        .pkt_valid(pkt_valid),
        .data_out (data_out),
        .tx_active(tx_active),
        .done     (done),
        .req_err  (req_err),
        .stall_err(stall_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        @(negedge clock);
    endtask

    // one packet: start, load pay_q, transmit with busy plan, gap
    task automatic run_pkt(input logic [1:0] d, input int gap_pct,
                           input int bk, input int bn,
                           input int rnd_pct, input int rst_k);
        logic [7:0] exp_q[$];
        logic [7:0] par;
        logic [5:0] n;
        int         run;
        bit         sflag;
        int         ng;
        int         nb;
        n   = 6'(pay_q.size());
        par = {n, d};
        exp_q = {};
        exp_q.push_back({n, d});
        foreach (pay_q[i]) begin
            exp_q.push_back(pay_q[i]);
            par = par ^ pay_q[i];
        end
        exp_q.push_back(par);
        obs_q = {};
        run   = 0;
        sflag = 1'b0;

        start = 1'b1;
        dest  = d;
        len   = n;
        cyc();
        start = 1'b0;
        chk("acc_tx_active", 32'(tx_active), 1);
        chk("acc_pay_ready", 32'(pay_ready), 1);
        chk("acc_pkt_valid", 32'(pkt_valid), 0);
        chk("acc_stall_err", 32'(stall_err), 0);
        chk("acc_req_err", 32'(req_err), 0);

        for (int i = 0; i < int'(n); i++) begin
            ng = ($urandom_range(99) < gap_pct) ? $urandom_range(1, 3) : 0;
            for (int g = 0; g <= ng; g++) begin
                pay_valid = (g == ng);
                pay_data  = (g == ng) ? pay_q[i] : 8'($urandom);
                busy      = 1'($urandom_range(1));
                start     = 1'($urandom_range(1));
                dest      = 2'($urandom);
                len       = 6'($urandom);
                cyc();
                if (g < ng || i < int'(n) - 1) begin
                    chk("load_ready", 32'(pay_ready), 1);
                    chk("load_data", 32'(data_out), 0);
                    chk("load_valid", 32'(pkt_valid), 0);
                    chk("load_req_err", 32'(req_err), 0);
                    chk("load_stall", 32'(stall_err), 0);
                end
            end
        end
        pay_valid = 1'b0;
        start     = 1'b0;
        busy      = 1'b0;

        for (int k = 0; k <= int'(n) + 1; k++) begin
            nb = (k == bk) ? bn : 0;
            if (rnd_pct > 0 && $urandom_range(99) < rnd_pct) begin
                nb += $urandom_range(1, 3);
            end
            for (int b = 0; b <= nb; b++) begin
                chk("tx_data", 32'(data_out), 32'(exp_q[k]));
                chk("tx_valid", 32'(pkt_valid), (k <= int'(n)) ? 1 : 0);
                chk("tx_active", 32'(tx_active), 1);
                chk("tx_ready", 32'(pay_ready), 0);
                chk("tx_done", 32'(done), 0);
                chk("tx_stall", 32'(stall_err), 32'(sflag));
                if (k == rst_k) begin
                    #2 resetn = 1'b0;
                    #1;
                    chk("rst_valid", 32'(pkt_valid), 0);
                    chk("rst_data", 32'(data_out), 0);
                    chk("rst_active", 32'(tx_active), 0);
                    busy = 1'b0;
                    for (int r = 0; r < 3; r++) begin
                        cyc();
                        chk("rst_done", 32'(done), 0);
                        chk("rst_hold_active", 32'(tx_active), 0);
                    end
                    resetn = 1'b1;
                    return;
                end
                if (b == nb) begin
                    obs_q.push_back(data_out);
                end
                busy = (b < nb);
                cyc();
                if (b < nb) begin
                    run++;
                    if (run >= SMAX) begin
                        sflag = 1'b1;
                    end
                end else begin
                    run = 0;
                end
            end
        end
        busy = 1'b0;

        chk("par_done", 32'(done), 1);
        chk("gap_data", 32'(data_out), 0);
        chk("gap_valid", 32'(pkt_valid), 0);
        chk("gap_active", 32'(tx_active), 1);
        chk("gap_stall", 32'(stall_err), 32'(sflag));
        for (int g = 1; g < GAP; g++) begin
            cyc();
            chk("gap_done_low", 32'(done), 0);
            chk("gap_data2", 32'(data_out), 0);
            chk("gap_active2", 32'(tx_active), 1);
        end
        cyc();
        chk("idle_active", 32'(tx_active), 0);
        chk("idle_done", 32'(done), 0);
        chk("idle_data", 32'(data_out), 0);
    endtask

    // illegal request must pulse req_err once and leave the block idle
    task automatic bad_req(input logic [1:0] d, input logic [5:0] n);
        start = 1'b1;
        dest  = d;
        len   = n;
        cyc();
        start = 1'b0;
        chk("bad_req_err", 32'(req_err), 1);
        chk("bad_ready", 32'(pay_ready), 0);
        chk("bad_active", 32'(tx_active), 0);
        chk("bad_valid", 32'(pkt_valid), 0);
        cyc();
        chk("bad_req_low", 32'(req_err), 0);
        chk("bad_active2", 32'(tx_active), 0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        resetn    = 1'b0;
        start     = 1'b0;
        dest      = 2'd0;
        len       = 6'd0;
        pay_valid = 1'b0;
        pay_data  = 8'd0;
        busy      = 1'b0;
        @(negedge clock);
        cyc();
        chk("rst_pay_ready", 32'(pay_ready), 0);
        chk("rst_pkt_valid", 32'(pkt_valid), 0);
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_tx_active", 32'(tx_active), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_req_err", 32'(req_err), 0);
        chk("rst_stall_err", 32'(stall_err), 0);
        resetn = 1'b1;
        cyc();

        // basic packet
        pay_q = {8'h11, 8'h22, 8'h44};
        run_pkt(2'd1, 0, -1, 0, 0, -1);
        chk("basic_count", obs_q.size(), 5);
        chk("basic_hdr", 32'(obs_q[0]), 32'h0D);
        chk("basic_p2", 32'(obs_q[3]), 32'h44);
        chk("basic_par", 32'(obs_q[4]), 32'h7A);

        // back-pressure on the 0x22 byte
        run_pkt(2'd1, 0, 2, 3, 0, -1);
        chk("bp_par", 32'(obs_q[4]), 32'h7A);
        chk("bp_stall", 32'(stall_err), 0);

        // illegal requests
        bad_req(2'd3, 6'd5);
        bad_req(2'd0, 6'd0);

        // maximum length with host gaps
        pay_q = {};
        for (int i = 1; i <= 63; i++) begin
            pay_q.push_back(8'(i));
        end
        run_pkt(2'd2, 50, -1, 0, 0, -1);
        chk("max_count", obs_q.size(), 65);
        chk("max_hdr", 32'(obs_q[0]), 32'hFE);
        chk("max_last", 32'(obs_q[63]), 32'h3F);
        chk("max_par", 32'(obs_q[64]), 32'hFE);

        // stall timeout in header
        pay_q = {8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        run_pkt(2'd0, 0, 0, SMAX, 0, -1);
        chk("stall_sticky", 32'(stall_err), 1);
        bad_req(2'd3, 6'd1);
        chk("stall_kept", 32'(stall_err), 1);
        pay_q = {8'hA5};
        run_pkt(2'd2, 0, -1, 0, 0, -1);

        // one busy run short of the timeout
        pay_q = {8'h01, 8'h02};
        run_pkt(2'd1, 0, 1, SMAX - 1, 0, -1);
        chk("stall_short", 32'(stall_err), 0);

        // reset during payload, idx=1
        pay_q = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
        run_pkt(2'd0, 20, 2, 0, 0, 2);
        pay_q = {8'h77, 8'h88};
        run_pkt(2'd2, 0, -1, 0, 0, -1);

        // randomized packets
        for (int p = 0; p < 20; p++) begin
            int n;
            n = $urandom_range(1, 63);
            pay_q = {};
            for (int i = 0; i < n; i++) begin
                pay_q.push_back(8'($urandom));
            end
            run_pkt(2'($urandom_range(2)), 30, -1, 0, 30, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
